// File: rtl/bc_arb_pkg.sv
// Shared helpers for the round-robin arbiter: one-hot rotate, one-hot encode and
// thermometer mask. Vectors are carried at the maximum width and cut down by callers.
package bc_arb_pkg;

  localparam int MAX_N = 64;
  localparam int MAX_IDX_W = 6;

  typedef logic [MAX_N-1:0] vec_t;

  // Rotate left by one within an n-bit field; bit n-1 wraps to bit 0.
  function automatic vec_t rot_l1(input vec_t v, input int n);
    vec_t keep;
    vec_t res;
    keep = '0;
    for (int i = 0; i < MAX_N; i++) begin
      keep[i] = (i < n);
    end
    res = (v << 1) & keep;
    res[0] = v[n-1];
    return res;
  endfunction

  function automatic logic [MAX_IDX_W-1:0] oh2bin(input vec_t v);
    logic [MAX_IDX_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) b = b | MAX_IDX_W'(i);
    end
    return b;
  endfunction

  // Every bit at or above the set bit of a one-hot vector.
  function automatic vec_t hi_mask(input vec_t v);
    vec_t m;
    logic seen;
    m = '0;
    seen = 1'b0;
    for (int i = 0; i < MAX_N; i++) begin
      seen = seen | v[i];
      m[i] = seen;
    end
    return m;
  endfunction

endpackage

// File: rtl/bc_onehot_first.sv
// Combinational lowest-set-bit selector: keeps only the least significant 1 of iDat.
module bc_onehot_first #(
  parameter int W = 8
) (
  input  logic [W-1:0] iDat,
  output logic [W-1:0] oDat
);

  // below[i] is set when any bit under position i is set.
  logic [W:0] below;

  assign below[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign below[gi+1] = below[gi] | iDat[gi];
      assign oDat[gi]    = iDat[gi] & ~below[gi];
    end
  endgenerate

endmodule

// File: rtl/bc_rr_onehot_arb.sv
// Registered round-robin arbiter: two lowest-first passes (masked by the rotating
// priority pointer, then raw) feed a held one-hot grant with valid/ready handshake.
module bc_rr_onehot_arb
  import bc_arb_pkg::*;
#(
  parameter int N = 8,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     iReq,
  input  logic             iGntRdy,
  output logic             oGntVld,
  output logic [N-1:0]     oGnt,
  output logic [IDX_W-1:0] oGntIdx
);

  generate
    if (N < 2 || N > MAX_N) begin : g_bad_n
      $error("bc_rr_onehot_arb: N must be in 2..64");
    end
  endgenerate

  logic             gnt_vld_reg;
  logic [N-1:0]     gnt_reg;
  logic [IDX_W-1:0] gnt_idx_reg;
  logic [N-1:0]     ptr_reg;
  logic [N-1:0]     ptr_next;

  logic             hs;
  logic             free;
  logic [N-1:0]     hi;
  logic [N-1:0]     mreq;
  logic [N-1:0]     first_masked;
  logic [N-1:0]     first_raw;
  logic [N-1:0]     cand;
  logic [IDX_W-1:0] cand_idx;

  assign hs   = gnt_vld_reg & iGntRdy;
  assign free = ~gnt_vld_reg | hs;

  // The pointer steps past the winner only when its grant is consumed.
  assign ptr_next = hs ? N'(rot_l1(vec_t'(gnt_reg), N)) : ptr_reg;
  assign hi       = N'(hi_mask(vec_t'(ptr_next)));
  assign mreq     = iReq & hi;

  bc_onehot_first #(.W(N)) u_first_masked (
    .iDat (mreq),
    .oDat (first_masked)
  );

  bc_onehot_first #(.W(N)) u_first_raw (
    .iDat (iReq),
    .oDat (first_raw)
  );

  assign cand     = (|mreq) ? first_masked : first_raw;
  assign cand_idx = IDX_W'(oh2bin(vec_t'(cand)));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg     <= N'(1);
      gnt_vld_reg <= 1'b0;
      gnt_reg     <= '0;
      gnt_idx_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
      // A presented grant is held until accepted, whatever iReq does meanwhile.
      if (free) begin
        gnt_vld_reg <= |iReq;
        gnt_reg     <= cand;
        gnt_idx_reg <= cand_idx;
      end
    end
  end

  assign oGntVld = gnt_vld_reg;
  assign oGnt    = gnt_reg;
  assign oGntIdx = gnt_idx_reg;

endmodule

// File: tb/tb_bc_rr_onehot_arb.sv
// Directed bench for bc_rr_onehot_arb at N=4 with hand-computed expected grants.
module tb_bc_rr_onehot_arb;

  localparam int N = 4;
  localparam int IDX_W = 2;

  logic             clk;
  logic             rst;
  logic [N-1:0]     iReq;
  logic             iGntRdy;
  logic             oGntVld;
  logic [N-1:0]     oGnt;
  logic [IDX_W-1:0] oGntIdx;

  int errors = 0;
  int checks = 0;

  bc_rr_onehot_arb #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .iReq    (iReq),
    .iGntRdy (iGntRdy),
    .oGntVld (oGntVld),
    .oGnt    (oGnt),
    .oGntIdx (oGntIdx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic exp_vld,
                       input logic [N-1:0] exp_gnt, input logic [IDX_W-1:0] exp_idx);
    checks++;
    assert (oGntVld === exp_vld) else begin
      errors++;
      $error("FAIL %s vld: got %b want %b", tag, oGntVld, exp_vld);
    end
    checks++;
    assert (oGnt === exp_gnt) else begin
      errors++;
      $error("FAIL %s gnt: got %b want %b", tag, oGnt, exp_gnt);
    end
    checks++;
    assert (oGntIdx === exp_idx) else begin
      errors++;
      $error("FAIL %s idx: got %0d want %0d", tag, oGntIdx, exp_idx);
    end
    $display("step %-12s req=%b rdy=%b -> vld=%b gnt=%b idx=%0d", tag, iReq, iGntRdy,
             oGntVld, oGnt, oGntIdx);
  endtask

  initial begin
    rst = 1'b1;
    iReq = '0;
    iGntRdy = 1'b0;
    step();
    rst = 1'b0;
    check("reset", 1'b0, 4'b0000, 2'd0);

    // Idle
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle", 1'b0, 4'b0000, 2'd0);
    end

    // Alternating between two requesters
    iReq = 4'b1010; iGntRdy = 1'b1;
    step(); check("alt0", 1'b1, 4'b0010, 2'd1);
    step(); check("alt1", 1'b1, 4'b1000, 2'd3);
    step(); check("alt2", 1'b1, 4'b0010, 2'd1);
    step(); check("alt3", 1'b1, 4'b1000, 2'd3);

    // Backpressure: grant 0010 held while requests change
    iReq = 4'b0110;
    step(); check("bp_load", 1'b1, 4'b0010, 2'd1);
    iGntRdy = 1'b0;
    step(); check("bp_hold0", 1'b1, 4'b0010, 2'd1);
    iReq = 4'b0100;
    step(); check("bp_hold1", 1'b1, 4'b0010, 2'd1);
    iReq = 4'b0000;
    step(); check("bp_hold2", 1'b1, 4'b0010, 2'd1);
    step(); check("bp_hold3", 1'b1, 4'b0010, 2'd1);
    iReq = 4'b0100; iGntRdy = 1'b1;
    step(); check("bp_next", 1'b1, 4'b0100, 2'd2);

    // Pointer wrap from bit 3 back to bit 0
    iReq = 4'b1000;
    step(); check("wrap_top", 1'b1, 4'b1000, 2'd3);
    iReq = 4'b1001;
    step(); check("wrap_low", 1'b1, 4'b0001, 2'd0);
    step(); check("wrap_back", 1'b1, 4'b1000, 2'd3);

    // Single requester gets back-to-back grants
    iReq = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("single", 1'b1, 4'b0100, 2'd2);
    end

    // Reset while a grant is pending
    iGntRdy = 1'b0;
    step(); check("pend", 1'b1, 4'b0100, 2'd2);
    rst = 1'b1;
    step(); check("mid_rst", 1'b0, 4'b0000, 2'd0);
    rst = 1'b0; iReq = 4'b1111; iGntRdy = 1'b1;
    step(); check("post_rst0", 1'b1, 4'b0001, 2'd0);
    step(); check("post_rst1", 1'b1, 4'b0010, 2'd1);

    // Requests drop while ready: outputs clear
    iReq = 4'b0000;
    step(); check("drop", 1'b0, 4'b0000, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
